// File: rtl/ifetch.sv
// Instruction fetch unit: fetch PC, a DEPTH-entry {pc, ins} circular buffer and a valid/ready output port.
// Optional misaligned-redirect trap is built when IFETCH_MISALIGN_TRAP_EN is defined.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ins,
    output logic [31:0] out_pc,
    output logic        out_fault
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [31:0]      fetch_pc_r;
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic [31:0]      pc_buf_r  [DEPTH];
    logic [31:0]      ins_buf_r [DEPTH];

    logic        pop_s;
    logic        push_s;
    logic        halt_s;
    logic        trap_s;
    logic [31:0] target_pc_s;

    // Circular pointer increment; DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Redirect target decode: trap on misalignment or silently align.
    always_comb begin
        target_pc_s = redirect_pc;
        trap_s      = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
        if (redirect_pc[1:0] != 2'b00) begin
            trap_s = 1'b1;
        end else begin
            trap_s = 1'b0;
        end
`else
        target_pc_s = redirect_pc & 32'hFFFF_FFFC;
`endif
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic fault_r;

    // Sticky fault: set by a misaligned redirect, cleared by reset or an aligned redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_r <= 1'b0;
        end else if (redirect_valid) begin
            fault_r <= trap_s;
        end else begin
            fault_r <= fault_r;
        end
    end

    assign halt_s    = fault_r;
    assign out_fault = fault_r;
`else
    assign halt_s    = 1'b0;
    assign out_fault = 1'b0;
`endif

    // Handshake decode; a redirect overrides both push and pop.
    always_comb begin
        pop_s  = 1'b0;
        push_s = 1'b0;
        if (redirect_valid) begin
            pop_s  = 1'b0;
            push_s = 1'b0;
        end else begin
            pop_s  = (count_r != '0) && out_ready;
            push_s = !halt_s && ((count_r < FULL_CNT) || pop_s);
        end
    end

    // Fetch PC, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= '0;
        end else if (redirect_valid) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            if (trap_s) begin
                fetch_pc_r <= fetch_pc_r;
            end else begin
                fetch_pc_r <= target_pc_s;
            end
        end else begin
            if (push_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
                tail_r     <= ptr_inc(tail_r);
            end else begin
                fetch_pc_r <= fetch_pc_r;
                tail_r     <= tail_r;
            end
            if (pop_s) begin
                head_r <= ptr_inc(head_r);
            end else begin
                head_r <= head_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Buffer storage; contents are meaningless while the entry is not counted.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_buf_r[tail_r]  <= fetch_pc_r;
            ins_buf_r[tail_r] <= imem_data;
        end
    end

    assign imem_addr = fetch_pc_r;
    assign out_valid = (count_r != '0);
    assign out_pc    = pc_buf_r[head_r];
    assign out_ins   = ins_buf_r[head_r];

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: scoreboard of expected pcs, checked at the falling edge.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ins;
    logic [31:0] out_pc;
    logic        out_fault;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endfunction

    assign imem_data = mem_word(imem_addr);

    ifetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins),
        .out_pc(out_pc), .out_fault(out_fault)
    );

    task automatic apply_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Compare the head entry with the scoreboard front.
    task automatic check_head(input string tag);
        exp_pc = sb_q.pop_front();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL %s_valid got %0b want 1", tag, out_valid); end
        n_cmp++; if (out_pc !== exp_pc) begin n_bad++; $display("FAIL %s_pc got %h want %h", tag, out_pc, exp_pc); end
        n_cmp++; if (out_ins !== mem_word(exp_pc)) begin n_bad++; $display("FAIL %s_ins got %h want %h", tag, out_ins, mem_word(exp_pc)); end
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr got %h want 0", imem_addr); end
        n_cmp++; if (out_fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault got %0b want 0", out_fault); end
    endtask

    task automatic test_stream();
        apply_reset();
        out_ready = 1'b1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_c0_valid got %0b want 0", out_valid); end
        for (int i = 0; i < 5; i++) sb_q.push_back(32'(i * 4));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_head("stream");
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_bad++; $display("FAIL bp_hold got v=%0b pc=%h want v=1 pc=0", out_valid, out_pc); end
        end
        n_cmp++; if (imem_addr !== 32'h8) begin n_bad++; $display("FAIL bp_addr got %h want 8", imem_addr); end
        out_ready = 1'b1;
        sb_q.push_back(32'h0); sb_q.push_back(32'h4); sb_q.push_back(32'h8);
        for (int i = 0; i < 3; i++) begin
            check_head("bp_drain");
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_pc !== 32'h4 || imem_addr !== 32'hC) begin n_bad++; $display("FAIL redir_pre got pc=%h addr=%h want 4 c", out_pc, imem_addr); end
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        @(negedge clk);
        redirect_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL redir_flush got %0b want 0", out_valid); end
        sb_q.push_back(32'h10); sb_q.push_back(32'h14);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_head("redir");
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        sb_q.push_back(32'hFFFF_FFFC); sb_q.push_back(32'h0000_0000);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_head("wrap");
        end
    endtask

    task automatic test_misalign();
        apply_reset();
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h6;
        @(negedge clk);
        redirect_valid = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (out_fault !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL trap_hold got f=%0b v=%0b want f=1 v=0", out_fault, out_valid); end
            @(negedge clk);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h8;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_cmp++; if (out_fault !== 1'b0) begin n_bad++; $display("FAIL trap_clear got %0b want 0", out_fault); end
        sb_q.push_back(32'h8);
        @(negedge clk);
        check_head("trap_resume");
`else
        n_cmp++; if (out_fault !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL align_flush got f=%0b v=%0b want 0 0", out_fault, out_valid); end
        sb_q.push_back(32'h4); sb_q.push_back(32'h8);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_head("align");
        end
`endif
    endtask

    task automatic test_reset_priority();
        apply_reset();
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL prio_valid got %0b want 0", out_valid); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL prio_addr got %h want 0", imem_addr); end
        rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
        sb_q.push_back(32'h0);
        @(negedge clk);
        check_head("prio_restart");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        sb_q.push_back(32'h0);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                sb_q.push_back(sb_q[0] + 32'd4);
                check_head("b2b");
            end
        end
        sb_q.delete();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_misalign();
        test_reset_priority();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
